// File: rtl/seg7_scan_mux_if.sv
// Update channel for seg7_scan_mux: a new digit/dot pattern offered with a valid/ready handshake.
// The master offers the pattern and the slave (the display block) reports when it can take one.
interface seg7_scan_mux_if;
  logic [15:0] in_digits;
  logic [3:0]  in_dots;
  logic        in_valid;
  logic        in_ready;

  modport master (
    output in_digits,
    output in_dots,
    output in_valid,
    input  in_ready
  );

  modport slave (
    input  in_digits,
    input  in_dots,
    input  in_valid,
    output in_ready
  );
endinterface

// File: rtl/seg7_scan_mux.sv
// Four-digit multiplexed 7-segment scanner with double-buffered, frame-synchronous updates,
// per-slot blanking and optional leading-zero suppression.
module seg7_scan_mux #(
  parameter int unsigned SLOT_CYCLES  = 10000,
  parameter int unsigned BLANK_CYCLES = 100
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_scan_mux_if.slave        upd_if,
  input  logic                  blank_lz,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [3:0]            an,
  output logic                  frame_done
);

  localparam int unsigned    CntW    = (SLOT_CYCLES > 2) ? $clog2(SLOT_CYCLES) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(SLOT_CYCLES - 1);

  // Scan position
  logic [CntW-1:0] r_cnt;
  logic [1:0]      r_idx;

  // Double-buffered display contents
  logic [15:0] r_act_digits;
  logic [3:0]  r_act_dots;
  logic [15:0] r_sh_digits;
  logic [3:0]  r_sh_dots;
  logic        r_pending;

  // Registered outputs
  logic [6:0] r_seg;
  logic       r_dp;
  logic [3:0] r_an;
  logic       r_frame_done;

  logic       w_slot_end;
  logic       w_boundary;
  logic       w_accept;
  logic       w_transfer;
  logic       w_blank;
  logic [3:0] w_nibble;
  logic       w_dot;
  logic [3:0] w_zero_from;
  logic       w_suppress;
  logic [6:0] w_seg_dec;
  logic [6:0] w_seg_nxt;
  logic       w_dp_nxt;
  logic [3:0] w_an_nxt;

  function automatic logic [6:0] decode_hex(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h40;
    endcase
    return s;
  endfunction

  assign upd_if.in_ready = !r_pending && !rst;

  assign w_slot_end = (r_cnt == CntLast);
  assign w_boundary = w_slot_end && (r_idx == 2'd3);
  assign w_accept   = upd_if.in_valid && upd_if.in_ready;
  // pending is known clear whenever w_accept is high, so a boundary-cycle capture waits a frame
  assign w_transfer = w_boundary && r_pending;
  assign w_blank    = 32'(r_cnt) < BLANK_CYCLES;

  always_comb begin
    w_nibble = 4'd0;
    w_dot    = 1'b0;
    unique case (r_idx)
      2'd0: begin w_nibble = r_act_digits[3:0];   w_dot = r_act_dots[0]; end
      2'd1: begin w_nibble = r_act_digits[7:4];   w_dot = r_act_dots[1]; end
      2'd2: begin w_nibble = r_act_digits[11:8];  w_dot = r_act_dots[2]; end
      2'd3: begin w_nibble = r_act_digits[15:12]; w_dot = r_act_dots[3]; end
      default: ;
    endcase
  end

  // w_zero_from[k]: active nibbles k..3 are all zero
  always_comb begin
    w_zero_from[3] = (r_act_digits[15:12] == 4'd0);
    w_zero_from[2] = w_zero_from[3] && (r_act_digits[11:8] == 4'd0);
    w_zero_from[1] = w_zero_from[2] && (r_act_digits[7:4] == 4'd0);
    w_zero_from[0] = w_zero_from[1] && (r_act_digits[3:0] == 4'd0);
  end

  assign w_suppress = blank_lz && (r_idx != 2'd0) && w_zero_from[r_idx];
  assign w_seg_dec  = decode_hex(w_nibble);

  always_comb begin
    w_seg_nxt = 7'd0;
    w_dp_nxt  = 1'b0;
    w_an_nxt  = 4'd0;
    if (!w_blank) begin
      w_an_nxt  = 4'b0001 << r_idx;
      w_dp_nxt  = w_dot;
      w_seg_nxt = w_suppress ? 7'd0 : w_seg_dec;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_idx <= 2'd0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_act_digits <= 16'd0;
      r_act_dots   <= 4'd0;
      r_sh_digits  <= 16'd0;
      r_sh_dots    <= 4'd0;
      r_pending    <= 1'b0;
    end else begin
      if (w_transfer) begin
        r_act_digits <= r_sh_digits;
        r_act_dots   <= r_sh_dots;
      end
      if (w_accept) begin
        r_sh_digits <= upd_if.in_digits;
        r_sh_dots   <= upd_if.in_dots;
        r_pending   <= 1'b1;
      end else if (w_transfer) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_seg        <= 7'd0;
      r_dp         <= 1'b0;
      r_an         <= 4'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_seg        <= w_seg_nxt;
      r_dp         <= w_dp_nxt;
      r_an         <= w_an_nxt;
      r_frame_done <= w_boundary;
    end
  end

  assign seg        = r_seg;
  assign dp         = r_dp;
  assign an         = r_an;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Bench for seg7_scan_mux: a time-based reference model checked every cycle, plus directed
// scenarios with hand-computed literal expectations.
module tb_seg7_scan_mux;
  localparam int unsigned S = 8;
  localparam int unsigned B = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       blank_lz;
  logic [6:0] seg;
  logic       dp;
  logic [3:0] an;
  logic       frame_done;

  seg7_scan_mux_if u_if ();

  seg7_scan_mux #(
    .SLOT_CYCLES (S),
    .BLANK_CYCLES(B)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .upd_if    (u_if),
    .blank_lz  (blank_lz),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at time %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the scan derived from cycle count since reset
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                7'h7F, 7'h6F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
  end

  initial begin
    int unsigned m_t;
    logic [15:0] m_act_d, m_sh_d;
    logic [3:0]  m_act_p, m_sh_p;
    bit          m_pend;
    logic [6:0]  e_seg;
    logic        e_dp, e_fd;
    logic [3:0]  e_an;
    int unsigned slot, pos;
    bit          s_rst, s_valid, s_blz, acc, sup;
    logic [15:0] s_dig;
    logic [3:0]  s_dot, nib;
    m_t = 0; m_act_d = 0; m_sh_d = 0; m_act_p = 0; m_sh_p = 0; m_pend = 0;
    forever begin
      @(posedge clk);
      s_rst = rst; s_valid = u_if.in_valid; s_blz = blank_lz;
      s_dig = u_if.in_digits; s_dot = u_if.in_dots;
      e_seg = 0; e_dp = 0; e_an = 0; e_fd = 0;
      if (s_rst) begin
        m_t = 0; m_act_d = 0; m_sh_d = 0; m_act_p = 0; m_sh_p = 0; m_pend = 0;
      end else begin
        slot = (m_t / S) % 4;
        pos  = m_t % S;
        if (pos >= B) begin
          nib   = 4'((m_act_d >> (4 * slot)) & 16'hF);
          sup   = s_blz && (slot != 0) && ((m_act_d >> (4 * slot)) == 16'd0);
          e_an  = 4'(1 << slot);
          e_dp  = m_act_p[slot];
          e_seg = sup ? 7'd0 : seg_tab[nib];
        end
        e_fd = (m_t % (4 * S)) == (4 * S - 1);
        acc  = s_valid && !m_pend;
        if (e_fd && m_pend) begin
          m_act_d = m_sh_d; m_act_p = m_sh_p; m_pend = 0;
        end
        if (acc) begin
          m_sh_d = s_dig; m_sh_p = s_dot; m_pend = 1;
        end
        m_t++;
      end
      #1;
      check("model_seg", 32'(seg), 32'(e_seg));
      check("model_dp", 32'(dp), 32'(e_dp));
      check("model_an", 32'(an), 32'(e_an));
      check("model_frame_done", 32'(frame_done), 32'(e_fd));
      check("model_in_ready", 32'(u_if.in_ready), 32'(!m_pend && !rst));
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
    n++;
  endtask

  task automatic run_to(input int target);
    while (n < target) tick();
  endtask

  task automatic expect_disp(input string name, input logic [3:0] e_an, input logic [6:0] e_seg,
                             input logic e_dp);
    check({name, "_an"}, 32'(an), 32'(e_an));
    check({name, "_seg"}, 32'(seg), 32'(e_seg));
    check({name, "_dp"}, 32'(dp), 32'(e_dp));
  endtask

  initial begin
    rst = 1'b1; blank_lz = 1'b0;
    u_if.in_valid = 1'b0; u_if.in_digits = 16'h0; u_if.in_dots = 4'h0;
    repeat (3) tick();
    expect_disp("reset", 4'h0, 7'h00, 1'b0);
    check("reset_fd", 32'(frame_done), 32'd0);
    check("reset_ready", 32'(u_if.in_ready), 32'd0);
    rst = 1'b0; n = 0;

    // Output-cycle numbering: n == output cycle after reset release
    run_to(1);  check("oc1_an", 32'(an), 32'd0);
    run_to(2);  check("oc2_an", 32'(an), 32'd0);
    run_to(3);  expect_disp("oc3", 4'b0001, 7'h3F, 1'b0);
    run_to(8);  expect_disp("oc8", 4'b0001, 7'h3F, 1'b0);
    run_to(9);  check("oc9_an", 32'(an), 32'd0);
    run_to(11); expect_disp("oc11", 4'b0010, 7'h3F, 1'b0);
    run_to(31); check("oc31_fd", 32'(frame_done), 32'd0);
    run_to(32); check("oc32_fd", 32'(frame_done), 32'd1);
    run_to(33); check("oc33_fd", 32'(frame_done), 32'd0);

    // First update, then a second offer held while the first is pending
    run_to(40);
    check("ready_before_offer", 32'(u_if.in_ready), 32'd1);
    u_if.in_digits = 16'h1234; u_if.in_dots = 4'b0100; u_if.in_valid = 1'b1;
    run_to(41);
    check("ready_after_accept", 32'(u_if.in_ready), 32'd0);
    u_if.in_digits = 16'h9999; u_if.in_dots = 4'b0000;
    run_to(43); expect_disp("still_old", 4'b0010, 7'h3F, 1'b0);
    run_to(64); check("ready_after_xfer", 32'(u_if.in_ready), 32'd1);
    run_to(65); check("ready_second_accept", 32'(u_if.in_ready), 32'd0);
    u_if.in_valid = 1'b0;
    run_to(70); expect_disp("u1_d0", 4'b0001, 7'h66, 1'b0);
    run_to(78); expect_disp("u1_d1", 4'b0010, 7'h4F, 1'b0);
    run_to(86); expect_disp("u1_d2", 4'b0100, 7'h5B, 1'b1);
    run_to(94); expect_disp("u1_d3", 4'b1000, 7'h06, 1'b0);
    run_to(102); expect_disp("u2_d0", 4'b0001, 7'h6F, 1'b0);
    run_to(118); expect_disp("u2_d2", 4'b0100, 7'h6F, 1'b0);

    // Leading-zero suppression
    run_to(130);
    blank_lz = 1'b1;
    u_if.in_digits = 16'h0050; u_if.in_dots = 4'b0000; u_if.in_valid = 1'b1;
    run_to(131); u_if.in_valid = 1'b0;
    run_to(166); expect_disp("lz_d0", 4'b0001, 7'h3F, 1'b0);
    run_to(174); expect_disp("lz_d1", 4'b0010, 7'h6D, 1'b0);
    run_to(182); expect_disp("lz_d2", 4'b0100, 7'h00, 1'b0);
    run_to(190); expect_disp("lz_d3", 4'b1000, 7'h00, 1'b0);
    run_to(192);
    u_if.in_digits = 16'hA000; u_if.in_valid = 1'b1;
    run_to(193); u_if.in_valid = 1'b0;
    run_to(230); expect_disp("a000_d0", 4'b0001, 7'h3F, 1'b0);
    run_to(238); expect_disp("a000_d1", 4'b0010, 7'h3F, 1'b0);
    run_to(246); expect_disp("a000_d2", 4'b0100, 7'h3F, 1'b0);
    run_to(254); expect_disp("a000_d3", 4'b1000, 7'h40, 1'b0);

    // Reset mid-slot with an update pending discards it
    run_to(260);
    blank_lz = 1'b0;
    u_if.in_digits = 16'h4321; u_if.in_dots = 4'hF; u_if.in_valid = 1'b1;
    run_to(261); u_if.in_valid = 1'b0;
    run_to(270); rst = 1'b1;
    run_to(271);
    expect_disp("rst_mid", 4'h0, 7'h00, 1'b0);
    check("rst_mid_fd", 32'(frame_done), 32'd0);
    check("rst_mid_ready", 32'(u_if.in_ready), 32'd0);
    rst = 1'b0; n = 0;
    run_to(1);  check("post_rst_ready", 32'(u_if.in_ready), 32'd1);
    run_to(5);  expect_disp("post_rst_d0", 4'b0001, 7'h3F, 1'b0);
    run_to(13); expect_disp("post_rst_d1", 4'b0010, 7'h3F, 1'b0);
    run_to(32); check("post_rst_fd", 32'(frame_done), 32'd1);
    run_to(37); expect_disp("discarded_d0", 4'b0001, 7'h3F, 1'b0);

    // Remaining decode values and dot placement
    run_to(40);
    u_if.in_digits = 16'h8765; u_if.in_dots = 4'b1010; u_if.in_valid = 1'b1;
    run_to(41); u_if.in_valid = 1'b0;
    run_to(70); expect_disp("dec_d0", 4'b0001, 7'h6D, 1'b0);
    run_to(78); expect_disp("dec_d1", 4'b0010, 7'h7D, 1'b1);
    run_to(86); expect_disp("dec_d2", 4'b0100, 7'h07, 1'b0);
    run_to(94); expect_disp("dec_d3", 4'b1000, 7'h7F, 1'b1);
    run_to(100);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_mux.md
SEG7_SCAN_MUX -- requirements
Module: seg7_scan_mux

Interface
REQ-001 Parameter SLOT_CYCLES, default 10000, clock cycles per digit slot; SHALL be >= 2.
REQ-002 Parameter BLANK_CYCLES, default 100, all-off cycles at the start of each slot; SHALL be < SLOT_CYCLES.
REQ-003 clk  in  1  the single clock; all state SHALL update on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 in_digits  in  16  four hex nibbles; digit0 = [3:0] (least significant), digit3 = [15:12].
REQ-006 in_dots  in  4  decimal-point request per digit; bit k belongs to digit k.
REQ-007 in_valid  in  1  an update is offered on in_digits/in_dots.
REQ-008 in_ready  out  1  the block can accept an update.
REQ-009 blank_lz  in  1  leading-zero suppression enable, sampled live.
REQ-010 seg  out  7  segment drive, active-high; seg[0]=a … seg[6]=g.
REQ-011 dp  out  1  decimal-point drive, active-high.
REQ-012 an  out  4  digit enable, one-hot active-high; bit k selects digit k.
REQ-013 frame_done  out  1  one-cycle pulse after each completed four-digit scan.

Function
REQ-014 Slot counter cnt: runs 0..SLOT_CYCLES-1, then wraps to 0 and advances digit index idx. idx runs 0→1→2→3→0.
REQ-015 The frame boundary SHALL be the cycle in which idx==3 and cnt==SLOT_CYCLES-1.
REQ-016 Storage: an active register (16 digit bits + 4 dot bits), a shadow register of the same width, and a pending flag.
REQ-017 in_ready SHALL equal !pending && !rst.
REQ-018 On in_valid && in_ready, the block SHALL capture in_digits/in_dots into shadow and set pending.
REQ-019 At a frame boundary with pending==1, shadow SHALL be copied to active and pending cleared in the same edge.
REQ-020 An update captured during a frame-boundary cycle SHALL NOT be transferred in that same cycle; it waits for the next boundary.
REQ-021 While in_ready is low, in_valid SHALL be ignored and shadow SHALL hold.
REQ-022 Decode (nibble→seg[6:0], hex):
  0:3F  1:06  2:5B  3:4F  4:66  5:6D  6:7D  7:07  8:7F  9:6F
  Values 10..15 SHALL decode to 40 (segment g only, a dash).
REQ-023 Digit k (k=1..3) SHALL be suppressed when blank_lz==1 and active nibbles k..3 are all zero. Digit 0 is never suppressed.
REQ-024 Suppression SHALL force seg=0 only; an and dp SHALL behave as for an unsuppressed digit.
REQ-025 seg, dp, an and frame_done SHALL be registered, reflecting the cnt/idx/active values of the previous cycle (latency 1).
REQ-026 When cnt < BLANK_CYCLES (evaluated one cycle earlier), an, seg and dp SHALL all be 0.
REQ-027 Otherwise:
  - an SHALL be 1<<idx.
  - seg SHALL be the decoded or suppressed value of active digit idx.
  - dp SHALL be active dot bit idx.
REQ-028 frame_done SHALL be 1 in the cycle after each frame boundary, and 0 otherwise.
REQ-029 No output SHALL ever assert more than one an bit.

Reset
REQ-030 While rst==1 at an edge:
  - cnt, idx, active, shadow and pending SHALL be cleared.
  - seg, dp, an and frame_done SHALL be 0.
  - in_ready SHALL be 0.
REQ-031 Reset asserted mid-slot or mid-frame SHALL discard any pending update; the next scan SHALL start at idx=0, cnt=0 on the first cycle after rst falls.

Verification (SLOT_CYCLES=8, BLANK_CYCLES=2)
REQ-032 Release reset, no update:
  - an=0 for output cycles 1-2.
  - Output cycles 3-8: an=0001, seg=3F, dp=0.
  - an=0010 from output cycle 11.
  - frame_done pulses once every 32 cycles.
REQ-033 Update handshake: while active is all zero, offer in_digits=0x1234, in_dots=0b0100.
  - in_ready drops the cycle after acceptance.
  - Display stays 0 until the next boundary.
  - In the following frame the digit slots show 66/0; 4F/0; 5B/1; 06/0 (seg/dp, digits 0..3).
  - in_ready rises again.
REQ-034 Second offer while pending: hold in_valid=1 with 0x9999. It SHALL be accepted only after the transfer of the first update, and shown one frame later.
REQ-035 blank_lz=1 with 0x0050:
  - Digits 3 and 2 show seg=0 while an still cycles through 1000/0100.
  - Digit 1 shows 6D and digit 0 shows 3F.
  - With 0xA000, digit 3 shows 40 and no digit is suppressed.
REQ-036 Assert rst for 1 cycle mid-slot with an update pending:
  - All outputs are 0 the next cycle.
  - pending is cleared and the display shows all 3F.
  - in_ready is 1 once rst is low.
